// File: rtl/output_unit_credit.sv
`default_nettype none
// ============================================================================
// Module   : output_unit_credit
// Purpose  : Registered per-direction link stage with downstream credit count.
// Revision : 1.0 - initial release
// ============================================================================
module output_unit_credit #(
  parameter int DATA_WIDTH = 36,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = 3,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid_i,
  input  logic [DATA_WIDTH-1:0] st_data_i,
  input  logic                  credit_decre_i,
  input  logic                  credit_in_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  credit_avail_o,
  output logic [CNT_WIDTH-1:0]  credit_count_o,
  output logic                  pending_o,
  output logic                  err_underflow_o,
  output logic                  err_overflow_o,
  output logic                  err_protocol_o,
  output logic [STAT_WIDTH-1:0] flit_sent_cnt_o
);

  localparam logic [CNT_WIDTH-1:0]  c_buf_depth = CNT_WIDTH'(BUF_DEPTH);
  localparam logic [CNT_WIDTH-1:0]  c_cnt_one   = CNT_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0] c_stat_one  = STAT_WIDTH'(1);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [CNT_WIDTH-1:0]  credit_q,    credit_d;
  logic                  pending_q,   pending_d;
  logic                  err_uf_q,    err_uf_d;
  logic                  err_of_q,    err_of_d;
  logic                  err_pe_q,    err_pe_d;
  logic [STAT_WIDTH-1:0] sent_q,      sent_d;

  always_comb begin
    out_valid_d = st_valid_i;
    out_data_d  = st_valid_i ? st_data_i : '0;
    credit_d    = credit_q;
    err_uf_d    = err_uf_q;
    err_of_d    = err_of_q;
    // Simultaneous consume and return cancel out, even at the limits.
    case ({credit_decre_i, credit_in_i})
      2'b10: begin
        if (credit_q == '0) err_uf_d = 1'b1;
        else                credit_d = credit_q - c_cnt_one;
      end
      2'b01: begin
        if (credit_q == c_buf_depth) err_of_d = 1'b1;
        else                         credit_d = credit_q + c_cnt_one;
      end
      default: ;
    endcase
    // A grant must be followed by its flit exactly one cycle later.
    pending_d = credit_decre_i;
    err_pe_d  = err_pe_q | (st_valid_i ^ pending_q);
    sent_d    = (out_valid_q && (sent_q != '1)) ? sent_q + c_stat_one : sent_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      credit_q    <= c_buf_depth;
      pending_q   <= 1'b0;
      err_uf_q    <= 1'b0;
      err_of_q    <= 1'b0;
      err_pe_q    <= 1'b0;
      sent_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      credit_q    <= credit_d;
      pending_q   <= pending_d;
      err_uf_q    <= err_uf_d;
      err_of_q    <= err_of_d;
      err_pe_q    <= err_pe_d;
      sent_q      <= sent_d;
    end
  end

  assign out_valid_o     = out_valid_q;
  assign out_data_o      = out_data_q;
  assign credit_count_o  = credit_q;
  assign credit_avail_o  = (credit_q != '0);
  assign pending_o       = pending_q;
  assign err_underflow_o = err_uf_q;
  assign err_overflow_o  = err_of_q;
  assign err_protocol_o  = err_pe_q;
  assign flit_sent_cnt_o = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_output_unit_credit.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_unit_credit
// Purpose  : Scoreboard bench for output_unit_credit against a clamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_unit_credit;

  localparam int c_depth = 4;
  localparam int c_smax  = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [35:0] st_data = '0;
  logic        credit_decre = 1'b0;
  logic        credit_in = 1'b0;
  logic        out_valid;
  logic [35:0] out_data;
  logic        credit_avail;
  logic [2:0]  credit_count;
  logic        pending;
  logic        err_underflow;
  logic        err_overflow;
  logic        err_protocol;
  logic [15:0] flit_sent_cnt;

  output_unit_credit dut (
    .clk             (clk),
    .rst             (rst),
    .st_valid_i      (st_valid),
    .st_data_i       (st_data),
    .credit_decre_i  (credit_decre),
    .credit_in_i     (credit_in),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
    .credit_avail_o  (credit_avail),
    .credit_count_o  (credit_count),
    .pending_o       (pending),
    .err_underflow_o (err_underflow),
    .err_overflow_o  (err_overflow),
    .err_protocol_o  (err_protocol),
    .flit_sent_cnt_o (flit_sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int cnt;
    bit pend;
    bit uf;
    bit of;
    bit pe;
    bit ov;
    int sent;
  } exp_t;

  exp_t        expq[$];
  logic [35:0] flitq[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference model: credits as a clamped integer, link as a one-deep delay.
  int m_cnt  = c_depth;
  bit m_pend = 0;
  bit m_uf = 0, m_of = 0, m_pe = 0;
  bit m_ov = 0;
  int m_sent = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step(input bit d, input bit ci, input bit sv,
                      input logic [35:0] data, input bit r);
    exp_t e;
    int   nc;
    @(posedge clk);
    #1;
    rst          = r;
    credit_decre = d;
    credit_in    = ci;
    st_valid     = sv;
    st_data      = data;
    if (r) begin
      m_cnt = c_depth; m_pend = 0; m_uf = 0; m_of = 0; m_pe = 0;
      m_ov = 0; m_sent = 0;
    end else begin
      if (m_ov) m_sent = (m_sent + 1 > c_smax) ? c_smax : m_sent + 1;
      m_ov = sv;
      if (sv) flitq.push_back(data);
      if (sv != m_pend) m_pe = 1;
      m_pend = d;
      nc = m_cnt + int'(ci) - int'(d);
      if (nc < 0)       begin nc = 0;       m_uf = 1; end
      if (nc > c_depth) begin nc = c_depth; m_of = 1; end
      m_cnt = nc;
    end
    e.cyc = cyc + 1; e.cnt = m_cnt; e.pend = m_pend; e.uf = m_uf;
    e.of = m_of; e.pe = m_pe; e.ov = m_ov; e.sent = m_sent;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  function automatic logic [35:0] rnd_flit();
    logic [3:0]  hi;
    logic [31:0] lo;
    hi = 4'($urandom_range(0, 15));
    lo = $urandom;
    return {hi, lo};
  endfunction

  // Monitor: state snapshot every cycle, flit data whenever the link is valid.
  always @(posedge clk) begin
    exp_t e;
    logic [35:0] f;
    #3;
    if (expq.size() > 0 && expq[0].cyc == cyc) begin
      e = expq.pop_front();
      chk("credit_count", credit_count, e.cnt);
      chk("credit_avail", credit_avail, e.cnt != 0);
      chk("pending", pending, e.pend);
      chk("err_underflow", err_underflow, e.uf);
      chk("err_overflow", err_overflow, e.of);
      chk("err_protocol", err_protocol, e.pe);
      chk("out_valid", out_valid, e.ov);
      chk("flit_sent_cnt", flit_sent_cnt, e.sent);
      if (!out_valid) chk("out_data_idle", out_data, 0);
    end
    if (out_valid) begin
      if (flitq.size() == 0) begin
        chk("unexpected_flit", 1, 0);
      end else begin
        f = flitq.pop_front();
        chk("out_data", out_data, f);
      end
    end
  end

  initial begin
    logic [35:0] base;
    bit d, ci;
    base = 36'h1_0002_00A0;

    // Reset and idle
    step(0, 0, 0, '0, 1);
    idle(5);

    // Four back-to-back grants drain the credits
    step(1, 0, 0, '0, 0);
    step(1, 0, 1, base + 0, 0);
    step(1, 0, 1, base + 1, 0);
    step(1, 0, 1, base + 2, 0);
    step(0, 0, 1, base + 3, 0);
    idle(3);

    // Consume + return at zero, then a lone return
    step(1, 1, 0, '0, 0);
    step(0, 1, 1, base + 4, 0);
    idle(1);

    // Underflow
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, base + 5, 0);
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, base + 6, 0);
    idle(2);

    // Overflow
    for (int i = 0; i < 5; i++) step(0, 1, 0, '0, 0);
    idle(2);

    // Protocol: flit without grant, then grant without flit
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, base + 7, 0);
    idle(2);
    step(0, 0, 0, '0, 1);
    step(1, 0, 0, '0, 0);
    idle(2);

    // Reset right after a grant, flit arriving during reset
    step(0, 0, 0, '0, 1);
    step(1, 0, 0, '0, 0);
    step(0, 0, 1, base + 8, 1);
    idle(3);

    // Random legal traffic
    for (int i = 0; i < 400; i++) begin
      d  = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
      ci = (m_cnt < c_depth) && ($urandom_range(0, 2) == 0);
      step(d, ci, m_pend, m_pend ? rnd_flit() : 36'h0, 0);
    end
    step(0, 0, m_pend, m_pend ? rnd_flit() : 36'h0, 0);
    idle(3);

    // Saturation of the sent-flit counter
    step(0, 0, 0, '0, 1);
    for (int i = 0; i < c_smax + 4; i++)
      step(1, 1, m_pend, m_pend ? rnd_flit() : 36'h0, 0);
    step(0, 0, 1, rnd_flit(), 0);
    idle(3);
    chk("sent_saturated", flit_sent_cnt, 16'hFFFF);

    repeat (3) @(posedge clk);
    #4;
    chk("scoreboard_drained", expq.size() + flitq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
